// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed hex display driver for a common-anode 7-segment module.
// The shown word is latched once per frame; leading zeros can be blanked and dp0 blinks on halt.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        halt,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  logic [SW-1:0] r_scan_cnt;
  logic [2:0]    r_idx;
  logic [31:0]   r_shadow;
  logic [FW-1:0] r_frame_cnt;
  logic          r_blink;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_tick;
  logic          w_frame_end;
  logic [31:0]   w_upper;
  logic [3:0]    w_nib;
  logic          w_blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_tick      = (r_scan_cnt == SCAN_MAX);
  assign w_frame_end = w_tick && (r_idx == 3'd7);
  // Everything at and above the current digit; zero means this digit is a leading zero.
  assign w_upper     = r_shadow >> {r_idx, 2'b00};
  assign w_nib       = w_upper[3:0];
  assign w_blank     = blank_lz && (r_idx != 3'd0) && (w_upper == 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= 3'd0;
      r_shadow   <= 32'd0;
    end else begin
      r_scan_cnt <= w_tick ? '0 : r_scan_cnt + 1'b1;
      if (w_tick)
        r_idx <= r_idx + 3'd1;
      if (w_frame_end)
        r_shadow <= data_in;
    end
  end

  // Leaving halt clears the blink phase so dp lights on the very next halted digit-0 slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (!halt) begin
      r_frame_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_frame_end) begin
      if (r_frame_cnt == FRAME_MAX) begin
        r_frame_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(8'b1 << r_idx);
      r_seg <= w_blank ? 7'h7F : hex_to_seg(w_nib);
      r_dp  <= !((r_idx == 3'd0) && halt && !r_blink);
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed and random scenarios checked each clock
// against a time-based model (digit = elapsed cycles / SCAN_DIV, blink from halted frame count).
module tb_seg7_scan_driver;

  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = SD * 8;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        halt;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  int          t_m;
  logic [31:0] shadow_m;
  int          halted_frames_m;

  logic [6:0] seg_tbl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .halt     (halt),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert (an === 8'hFF) else begin errors++; $error("FAIL %s an: observed %h expected ff", tag, an); end
    checks++;
    assert (seg === 7'h7F) else begin errors++; $error("FAIL %s seg: observed %h expected 7f", tag, seg); end
    checks++;
    assert (dp === 1'b1) else begin errors++; $error("FAIL %s dp: observed %b expected 1", tag, dp); end
  endtask

  task automatic model_reset();
    t_m             = 0;
    shadow_m        = 32'd0;
    halted_frames_m = 0;
  endtask

  // One clock: predict the outputs from elapsed time, advance the model, then compare.
  task automatic step();
    int          pos;
    logic [31:0] upper;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        blink_m;
    logic        frame_end;
    pos       = (t_m / SD) % 8;
    upper     = shadow_m >> (4 * pos);
    blink_m   = ((halted_frames_m / BF) % 2) == 1;
    e_an      = ~(8'd1 << pos);
    e_seg     = (blank_lz && pos != 0 && upper == 32'd0) ? 7'h7F : seg_tbl[upper[3:0]];
    e_dp      = (pos == 0 && halt && !blink_m) ? 1'b0 : 1'b1;
    frame_end = (t_m % FRAME) == FRAME - 1;
    if (frame_end)
      shadow_m = data_in;
    if (!halt)
      halted_frames_m = 0;
    else if (frame_end)
      halted_frames_m++;
    @(posedge clk);
    #1;
    t_m++;
    checks++;
    assert (an === e_an) else begin
      errors++; $error("FAIL an t=%0d: observed %h expected %h", t_m, an, e_an);
    end
    checks++;
    assert (seg === e_seg) else begin
      errors++; $error("FAIL seg t=%0d digit %0d: observed %h expected %h", t_m, pos, seg, e_seg);
    end
    checks++;
    assert (dp === e_dp) else begin
      errors++; $error("FAIL dp t=%0d digit %0d: observed %b expected %b", t_m, pos, dp, e_dp);
    end
  endtask

  task automatic run_frames(input int n);
    repeat (n * FRAME) step();
  endtask

  initial begin
    rst      = 1'b0;
    data_in  = 32'd0;
    halt     = 1'b0;
    blank_lz = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_held");
    rst = 1'b0;
    model_reset();
    $display("reset released");

    // Frame 0 shows zeros; 1234ABCD latched at its end, cleared mid-way through frame 1.
    data_in = 32'h1234ABCD;
    run_frames(1);
    $display("frame: data 1234abcd latched");
    repeat (FRAME / 2) step();
    data_in = 32'd0;
    repeat (FRAME / 2) step();
    $display("frame: mid-frame data change to 0");
    run_frames(1);

    blank_lz = 1'b1;
    data_in  = 32'h0000_00F0;
    run_frames(2);
    $display("frame: blank_lz with 000000f0");
    data_in = 32'd0;
    run_frames(2);
    $display("frame: blank_lz with 0");

    blank_lz = 1'b0;
    data_in  = 32'hDEAD_BEEF;
    halt     = 1'b1;
    run_frames(5);
    $display("frames: halt blinking");
    halt = 1'b0;
    run_frames(1);
    halt = 1'b1;
    run_frames(1);
    $display("frames: halt released then reasserted");

    for (int f = 0; f < 8; f++) begin
      data_in = $urandom >> (4 * $urandom_range(0, 7));
      for (int c = 0; c < FRAME; c++) begin
        if ($urandom_range(0, 7) == 0) blank_lz = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) halt = ~halt;
        step();
      end
      $display("random frame %0d data %h", f, data_in);
    end

    // Asynchronous reset while digit 5 is active, with a nonzero word on display.
    halt     = 1'b0;
    blank_lz = 1'b0;
    data_in  = 32'h8765_4321;
    run_frames(1);
    while (((t_m / SD) % 8) != 5) step();
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_midframe");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_frames(2);
    $display("frames: after mid-frame reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
